// File: rtl/cpu_pkg.sv
// Shared CPU definitions: request codes, controller state encoding and the
// request legality check used at acceptance time.
package cpu_pkg;

  // Request kind codes
  localparam logic [1:0] KIND_FETCH   = 2'b00;
  localparam logic [1:0] KIND_LOAD    = 2'b01;
  localparam logic [1:0] KIND_STORE   = 2'b10;
  localparam logic [1:0] KIND_ILLEGAL = 2'b11;

  // Request size codes
  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  // Memory access controller state encoding
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_WAIT = 3'd1;
  localparam logic [2:0] S_RESP    = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_ERR     = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = S_IDLE,
    ST_RD_WAIT = S_RD_WAIT,
    ST_RESP    = S_RESP,
    ST_WRITE   = S_WRITE,
    ST_ERR     = S_ERR
  } state_t;

  // True when a request cannot be served: reserved codes, a fetch that is
  // not a word, or an address not aligned to the access size.
  function automatic logic req_illegal(input logic [1:0] kind,
                                       input logic [1:0] size,
                                       input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    if ((kind == KIND_ILLEGAL) || (size == SZ_ILLEGAL)) begin
      bad = 1'b1;
    end else if ((kind == KIND_FETCH) && (size != SZ_WORD)) begin
      bad = 1'b1;
    end else if ((size == SZ_HALF) && lane[0]) begin
      bad = 1'b1;
    end else if ((size == SZ_WORD) && (lane != 2'b00)) begin
      bad = 1'b1;
    end else begin
      bad = 1'b0;
    end
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake between the control unit and the memory access
// controller, plus the controller's memory-side bus.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_kind;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic              ir_load;
  logic              exc_align;
  logic              busy;

  // Control unit and memory side
  modport master (
    output req_valid, req_kind, req_size, req_signed, req_addr, req_wdata,
    output mem_rdata,
    input  req_ready, mem_addr, mem_rd, mem_wr, mem_wdata,
    input  rsp_valid, rsp_data, ir_load, exc_align, busy
  );

  // Memory access controller side
  modport slave (
    input  req_valid, req_kind, req_size, req_signed, req_addr, req_wdata,
    input  mem_rdata,
    output req_ready, mem_addr, mem_rd, mem_wr, mem_wdata,
    output rsp_valid, rsp_data, ir_load, exc_align, busy
  );
endinterface

// File: rtl/mem_access_ctrl_byte_lane.sv
// Little-endian byte lane unit: extracts and extends sub-word load values and
// merges sub-word store data into a full memory word. Purely combinational.
module byte_lane_unit
  import cpu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed byte and halfword from the read word
  always_comb begin
    byte_s = 8'd0;
    case (lane)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = 8'd0;
    endcase
    if (lane[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Extend the selected value to 32 bits; words pass through untouched
  always_comb begin
    load_data = rdata;
    case (size)
      SZ_BYTE: load_data = {{24{sign & byte_s[7]}}, byte_s};
      SZ_HALF: load_data = {{16{sign & half_s[15]}}, half_s};
      default: load_data = rdata;
    endcase
  end

  // Replace the addressed lane(s) of the read word with right-justified store data
  always_comb begin
    merge_data = rdata;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0:    merge_data[7:0]   = wdata[7:0];
          2'd1:    merge_data[15:8]  = wdata[7:0];
          2'd2:    merge_data[23:16] = wdata[7:0];
          2'd3:    merge_data[31:24] = wdata[7:0];
          default: merge_data        = rdata;
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) begin
          merge_data[31:16] = wdata[15:0];
        end else begin
          merge_data[15:0] = wdata[15:0];
        end
      end
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: accepts one fetch/load/store request at a time,
// waits out the fixed read latency, does read-modify-write for sub-word
// stores and returns a one-cycle completion pulse. All outputs are registers.
module mem_access_ctrl
  import cpu_pkg::*;
#(
  parameter int MEM_LAT = 3,
  parameter int ADDR_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  mem_access_ctrl_if.slave bus
);

  localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

  state_t            state_r;
  logic [3:0]        cnt_r;
  logic [1:0]        kind_r;
  logic [1:0]        size_r;
  logic              sign_r;
  logic [1:0]        lane_r;
  logic [31:0]       wdata_r;

  logic              req_ready_r;
  logic              busy_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic              mem_rd_r;
  logic              mem_wr_r;
  logic [31:0]       mem_wdata_r;
  logic              rsp_valid_r;
  logic [31:0]       rsp_data_r;
  logic              ir_load_r;
  logic              exc_align_r;

  logic [31:0]       load_data_s;
  logic [31:0]       merge_data_s;

  // Lane logic works on the live read data so the value is captured on the
  // same edge that ends the last wait cycle.
  byte_lane_unit u_lane (
    .rdata      (bus.mem_rdata),
    .wdata      (wdata_r),
    .lane       (lane_r),
    .size       (size_r),
    .sign       (sign_r),
    .load_data  (load_data_s),
    .merge_data (merge_data_s)
  );

  // Access sequencer with its latency counter and all registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      kind_r      <= KIND_FETCH;
      size_r      <= SZ_BYTE;
      sign_r      <= 1'b0;
      lane_r      <= 2'b00;
      wdata_r     <= 32'd0;
      req_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_rd_r    <= 1'b0;
      mem_wr_r    <= 1'b0;
      mem_wdata_r <= 32'd0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 32'd0;
      ir_load_r   <= 1'b0;
      exc_align_r <= 1'b0;
    end else begin
      rsp_valid_r <= 1'b0;
      ir_load_r   <= 1'b0;
      exc_align_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.req_valid) begin
            kind_r      <= bus.req_kind;
            size_r      <= bus.req_size;
            sign_r      <= bus.req_signed;
            lane_r      <= bus.req_addr[1:0];
            wdata_r     <= bus.req_wdata;
            mem_addr_r  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            if (req_illegal(bus.req_kind, bus.req_size, bus.req_addr[1:0])) begin
              state_r     <= ST_ERR;
              exc_align_r <= 1'b1;
            end else if ((bus.req_kind == KIND_STORE) && (bus.req_size == SZ_WORD)) begin
              // Full-word store needs no read
              state_r     <= ST_WRITE;
              mem_wr_r    <= 1'b1;
              mem_wdata_r <= bus.req_wdata;
              rsp_valid_r <= 1'b1;
            end else begin
              state_r  <= ST_RD_WAIT;
              mem_rd_r <= 1'b1;
              cnt_r    <= 4'd0;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RD_WAIT: begin
          if (cnt_r == LAT_LAST) begin
            mem_rd_r    <= 1'b0;
            cnt_r       <= 4'd0;
            rsp_valid_r <= 1'b1;
            if (kind_r == KIND_STORE) begin
              state_r     <= ST_WRITE;
              mem_wr_r    <= 1'b1;
              mem_wdata_r <= merge_data_s;
            end else begin
              state_r    <= ST_RESP;
              rsp_data_r <= load_data_s;
              ir_load_r  <= (kind_r == KIND_FETCH);
            end
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        ST_RESP, ST_WRITE, ST_ERR: begin
          state_r     <= ST_IDLE;
          mem_rd_r    <= 1'b0;
          mem_wr_r    <= 1'b0;
          req_ready_r <= 1'b1;
          busy_r      <= 1'b0;
        end
        default: begin
          state_r     <= ST_IDLE;
          cnt_r       <= 4'd0;
          mem_rd_r    <= 1'b0;
          mem_wr_r    <= 1'b0;
          req_ready_r <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.busy      = busy_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_rd    = mem_rd_r;
  assign bus.mem_wr    = mem_wr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.ir_load   = ir_load_r;
  assign bus.exc_align = exc_align_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a latency-accurate
// memory model: read data is only correct in the last mem_rd cycle.
module tb_mem_access_ctrl;
  import cpu_pkg::*;

  localparam int          MEM_LAT = 3;
  localparam logic [31:0] JUNK    = 32'h5A5A_5A5A;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_W(32)) bus ();

  mem_access_ctrl #(.MEM_LAT(MEM_LAT), .ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int          obs_rd_cnt, obs_rd_first, obs_wr_cnt, obs_wr_cycle;
  int          obs_rsp_cnt, obs_rsp_cycle, obs_rsp_cycle2;
  int          obs_exc_cnt, obs_exc_cycle, obs_ready_cycle, obs_conflict;
  logic [31:0] obs_rsp_data, obs_wr_data, obs_wr_addr, obs_data_end;
  logic        obs_irl;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 presents the request; the bench then observes cycles 1..ncyc.
  task automatic run_access(input logic [1:0] kind, input logic [1:0] size,
                            input logic sgn, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] word,
                            input int hold, input int ncyc);
    int          run;
    logic        prev_en;
    logic [31:0] prev_addr;
    obs_rd_cnt = 0; obs_rd_first = -1; obs_wr_cnt = 0; obs_wr_cycle = -1;
    obs_rsp_cnt = 0; obs_rsp_cycle = -1; obs_rsp_cycle2 = -1;
    obs_exc_cnt = 0; obs_exc_cycle = -1; obs_ready_cycle = -1; obs_conflict = 0;
    obs_rsp_data = 32'd0; obs_wr_data = 32'd0; obs_wr_addr = 32'd0; obs_irl = 1'b0;
    run = 0;
    bus.req_kind = kind; bus.req_size = size; bus.req_signed = sgn;
    bus.req_addr = addr; bus.req_wdata = wdata;
    for (int c = 0; c <= ncyc; c++) begin
      if (c > 0) begin
        if (bus.mem_rd) begin
          obs_rd_cnt++;
          if (obs_rd_first < 0) obs_rd_first = c;
        end
        if (bus.mem_wr) begin
          obs_wr_cnt++; obs_wr_cycle = c;
          obs_wr_data = bus.mem_wdata; obs_wr_addr = bus.mem_addr;
        end
        if (bus.mem_rd && bus.mem_wr) obs_conflict++;
        if (prev_en && (bus.mem_rd || bus.mem_wr) && (bus.mem_addr !== prev_addr)) obs_conflict++;
        if (bus.busy === bus.req_ready) obs_conflict++;
        if (bus.rsp_valid) begin
          obs_rsp_cnt++;
          if (obs_rsp_cnt == 1) begin
            obs_rsp_cycle = c; obs_irl = bus.ir_load;
          end else begin
            obs_rsp_cycle2 = c;
          end
          obs_rsp_data = bus.rsp_data;
        end
        if (bus.exc_align) begin
          obs_exc_cnt++; obs_exc_cycle = c;
        end
        if (bus.req_ready && (obs_ready_cycle < 0)) obs_ready_cycle = c;
      end
      prev_en   = bus.mem_rd | bus.mem_wr;
      prev_addr = bus.mem_addr;
      run       = bus.mem_rd ? run + 1 : 0;
      bus.mem_rdata = (run == MEM_LAT) ? word : JUNK;
      bus.req_valid = (c < hold);
      if (c < ncyc) tick();
    end
    obs_data_end  = bus.rsp_data;
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0]  flags;
    logic [95:0] data;
    flags = {bus.req_ready, bus.busy, bus.mem_rd, bus.mem_wr, bus.rsp_valid, bus.ir_load, bus.exc_align};
    data  = {bus.rsp_data, bus.mem_addr, bus.mem_wdata};
    n_checks++; if (flags !== 7'b1000000) begin n_fail++; $display("FAIL reset_flags: got %b expected %b", flags, 7'b1000000); end
    n_checks++; if (data !== 96'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", data); end
  endtask

  task automatic test_fetch();
    run_access(KIND_FETCH, SZ_WORD, 1'b0, 32'h0000_0010, 32'd0, 32'h8C22_0004, 1, 6);
    n_checks++; if (obs_rd_first !== 1) begin n_fail++; $display("FAIL fetch_rd_first: got %0d expected 1", obs_rd_first); end
    n_checks++; if (obs_rd_cnt !== 3) begin n_fail++; $display("FAIL fetch_rd_cnt: got %0d expected 3", obs_rd_cnt); end
    n_checks++; if (obs_rsp_cycle !== 4) begin n_fail++; $display("FAIL fetch_rsp_cycle: got %0d expected 4", obs_rsp_cycle); end
    n_checks++; if (obs_irl !== 1'b1) begin n_fail++; $display("FAIL fetch_ir_load: got %b expected 1", obs_irl); end
    n_checks++; if (obs_rsp_data !== 32'h8C22_0004) begin n_fail++; $display("FAIL fetch_data: got %h expected 8c220004", obs_rsp_data); end
    n_checks++; if ((obs_rsp_cnt !== 1) || (obs_wr_cnt !== 0)) begin n_fail++; $display("FAIL fetch_counts: got rsp=%0d wr=%0d expected rsp=1 wr=0", obs_rsp_cnt, obs_wr_cnt); end
    n_checks++; if (obs_ready_cycle !== 5) begin n_fail++; $display("FAIL fetch_ready: got %0d expected 5", obs_ready_cycle); end
    n_checks++; if (obs_data_end !== 32'h8C22_0004) begin n_fail++; $display("FAIL fetch_hold: got %h expected 8c220004", obs_data_end); end
    n_checks++; if (obs_conflict !== 0) begin n_fail++; $display("FAIL fetch_bus_rules: got %0d violations expected 0", obs_conflict); end
  endtask

  // {size, signed, addr, expected}; memory word 0x80FF_1234
  localparam logic [66:0] LD_TAB [8] = '{
    {SZ_BYTE, 1'b1, 32'h13, 32'hFFFF_FF80},
    {SZ_BYTE, 1'b0, 32'h13, 32'h0000_0080},
    {SZ_HALF, 1'b1, 32'h12, 32'hFFFF_80FF},
    {SZ_HALF, 1'b0, 32'h12, 32'h0000_80FF},
    {SZ_BYTE, 1'b1, 32'h10, 32'h0000_0034},
    {SZ_HALF, 1'b1, 32'h10, 32'h0000_1234},
    {SZ_BYTE, 1'b1, 32'h12, 32'hFFFF_FFFF},
    {SZ_WORD, 1'b1, 32'h10, 32'h80FF_1234}
  };

  task automatic test_loads();
    logic [66:0] row;
    for (int i = 0; i < 8; i++) begin
      row = LD_TAB[i];
      run_access(KIND_LOAD, row[66:65], row[64], row[63:32], 32'd0, 32'h80FF_1234, 1, 6);
      n_checks++; if (obs_rsp_data !== row[31:0]) begin n_fail++; $display("FAIL load_data[%0d]: got %h expected %h", i, obs_rsp_data, row[31:0]); end
      n_checks++; if ((obs_rsp_cycle !== 4) || (obs_irl !== 1'b0) || (obs_rd_cnt !== 3) || (obs_wr_cnt !== 0) || (obs_conflict !== 0)) begin
        n_fail++; $display("FAIL load_timing[%0d]: got rsp=%0d irl=%b rd=%0d wr=%0d viol=%0d expected rsp=4 irl=0 rd=3 wr=0 viol=0", i, obs_rsp_cycle, obs_irl, obs_rd_cnt, obs_wr_cnt, obs_conflict);
      end
    end
  endtask

  // {size, addr, wdata, expected merged word}; memory word 0x1122_3344
  localparam logic [97:0] ST_TAB [3] = '{
    {SZ_BYTE, 32'h21, 32'h0000_00AB, 32'h1122_AB44},
    {SZ_HALF, 32'h22, 32'hCAFE_BEEF, 32'hBEEF_3344},
    {SZ_BYTE, 32'h23, 32'h1234_5677, 32'h7722_3344}
  };

  task automatic test_store_sub();
    logic [97:0] row;
    for (int i = 0; i < 3; i++) begin
      row = ST_TAB[i];
      run_access(KIND_STORE, row[97:96], 1'b0, row[95:64], row[63:32], 32'h1122_3344, 1, 6);
      n_checks++; if (obs_wr_data !== row[31:0]) begin n_fail++; $display("FAIL store_merge[%0d]: got %h expected %h", i, obs_wr_data, row[31:0]); end
      n_checks++; if (obs_wr_addr !== 32'h0000_0020) begin n_fail++; $display("FAIL store_addr[%0d]: got %h expected 00000020", i, obs_wr_addr); end
      n_checks++; if ((obs_wr_cnt !== 1) || (obs_wr_cycle !== 4) || (obs_rsp_cycle !== 4) || (obs_rd_cnt !== 3) || (obs_conflict !== 0)) begin
        n_fail++; $display("FAIL store_timing[%0d]: got wr=%0d@%0d rsp=%0d rd=%0d viol=%0d expected wr=1@4 rsp=4 rd=3 viol=0", i, obs_wr_cnt, obs_wr_cycle, obs_rsp_cycle, obs_rd_cnt, obs_conflict);
      end
    end
  endtask

  task automatic test_store_word();
    run_access(KIND_STORE, SZ_WORD, 1'b0, 32'h0000_0024, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1, 4);
    n_checks++; if (obs_rd_cnt !== 0) begin n_fail++; $display("FAIL sw_no_read: got %0d expected 0", obs_rd_cnt); end
    n_checks++; if ((obs_wr_cnt !== 1) || (obs_wr_cycle !== 1) || (obs_rsp_cycle !== 1)) begin
      n_fail++; $display("FAIL sw_timing: got wr=%0d@%0d rsp=%0d expected wr=1@1 rsp=1", obs_wr_cnt, obs_wr_cycle, obs_rsp_cycle);
    end
    n_checks++; if ((obs_wr_data !== 32'hDEAD_BEEF) || (obs_wr_addr !== 32'h0000_0024)) begin
      n_fail++; $display("FAIL sw_data: got %h@%h expected deadbeef@00000024", obs_wr_data, obs_wr_addr);
    end
    n_checks++; if (obs_ready_cycle !== 2) begin n_fail++; $display("FAIL sw_ready: got %0d expected 2", obs_ready_cycle); end
  endtask

  // {kind, size, addr} of requests that must raise exc_align
  localparam logic [35:0] BAD_TAB [7] = '{
    {KIND_LOAD,    SZ_WORD,    32'h26},
    {KIND_LOAD,    SZ_HALF,    32'h13},
    {KIND_FETCH,   SZ_BYTE,    32'h10},
    {KIND_FETCH,   SZ_WORD,    32'h12},
    {KIND_ILLEGAL, SZ_WORD,    32'h10},
    {KIND_STORE,   SZ_ILLEGAL, 32'h20},
    {KIND_STORE,   SZ_HALF,    32'h21}
  };

  task automatic test_align();
    logic [35:0] row;
    for (int i = 0; i < 7; i++) begin
      row = BAD_TAB[i];
      run_access(row[35:34], row[33:32], 1'b0, row[31:0], 32'hFFFF_FFFF, 32'h1122_3344, 1, 4);
      n_checks++; if ((obs_exc_cnt !== 1) || (obs_exc_cycle !== 1) || (obs_rd_cnt !== 0) || (obs_wr_cnt !== 0) || (obs_rsp_cnt !== 0) || (obs_ready_cycle !== 2)) begin
        n_fail++; $display("FAIL align[%0d]: got exc=%0d@%0d rd=%0d wr=%0d rsp=%0d ready=%0d expected exc=1@1 rd=0 wr=0 rsp=0 ready=2", i, obs_exc_cnt, obs_exc_cycle, obs_rd_cnt, obs_wr_cnt, obs_rsp_cnt, obs_ready_cycle);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] flags;
    int         wr_seen;
    bus.req_kind = KIND_STORE; bus.req_size = SZ_HALF; bus.req_signed = 1'b0;
    bus.req_addr = 32'h22; bus.req_wdata = 32'h0000_1111; bus.mem_rdata = JUNK;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    tick();
    n_checks++; if (bus.mem_rd !== 1'b1) begin n_fail++; $display("FAIL sh_reading: got %b expected 1", bus.mem_rd); end
    reset = 1'b0;
    #1;
    flags = {bus.req_ready, bus.busy, bus.mem_rd, bus.mem_wr, bus.rsp_valid, bus.ir_load, bus.exc_align};
    n_checks++; if (flags !== 7'b1000000) begin n_fail++; $display("FAIL async_reset_flags: got %b expected %b", flags, 7'b1000000); end
    n_checks++; if (bus.mem_addr !== 32'd0) begin n_fail++; $display("FAIL async_reset_addr: got %h expected 0", bus.mem_addr); end
    wr_seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) reset = 1'b1;
      tick();
      if (bus.mem_wr || bus.rsp_valid) wr_seen++;
    end
    n_checks++; if (wr_seen !== 0) begin n_fail++; $display("FAIL abort_no_write: got %0d write cycles expected 0", wr_seen); end
    run_access(KIND_FETCH, SZ_WORD, 1'b0, 32'h0000_0040, 32'd0, 32'h0123_4567, 1, 6);
    n_checks++; if ((obs_rsp_cycle !== 4) || (obs_rsp_data !== 32'h0123_4567) || (obs_irl !== 1'b1)) begin
      n_fail++; $display("FAIL post_reset_fetch: got rsp=%0d data=%h irl=%b expected rsp=4 data=01234567 irl=1", obs_rsp_cycle, obs_rsp_data, obs_irl);
    end
  endtask

  task automatic test_back_to_back();
    // req_valid stays high through cycle 5, the first IDLE cycle after completion
    run_access(KIND_LOAD, SZ_BYTE, 1'b0, 32'h13, 32'd0, 32'h80FF_1234, 6, 12);
    n_checks++; if ((obs_rsp_cnt !== 2) || (obs_rsp_cycle !== 4) || (obs_rsp_cycle2 !== 9)) begin
      n_fail++; $display("FAIL b2b_rsp: got %0d rsp at %0d,%0d expected 2 rsp at 4,9", obs_rsp_cnt, obs_rsp_cycle, obs_rsp_cycle2);
    end
    n_checks++; if ((obs_rd_cnt !== 6) || (obs_ready_cycle !== 5)) begin
      n_fail++; $display("FAIL b2b_reads: got rd=%0d ready=%0d expected rd=6 ready=5", obs_rd_cnt, obs_ready_cycle);
    end
    n_checks++; if ((obs_rsp_data !== 32'h0000_0080) || (obs_conflict !== 0)) begin
      n_fail++; $display("FAIL b2b_data: got %h viol=%0d expected 00000080 viol=0", obs_rsp_data, obs_conflict);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_kind = KIND_FETCH; bus.req_size = SZ_WORD;
    bus.req_signed = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    bus.mem_rdata = JUNK;
    #2 reset = 1'b0;
    tick();
    tick();
    test_reset();
    reset = 1'b1;
    tick();
    test_fetch();
    test_loads();
    test_store_sub();
    test_store_word();
    test_align();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences every access to the single-port, byte-addressed, word-wide instruction/data memory on behalf of the multicycle control unit.
- The control unit issues one request per instruction phase: instruction fetch, load (LB/LBU/LH/LHU/LW) or store (SB/SH/SW).
- The block handles the fixed memory read latency, word alignment, sub-word extraction and sign extension, and read-modify-write for sub-word stores.
- It returns a one-cycle completion pulse, so the control unit no longer counts wait states itself.

Parameters:
- MEM_LAT, 3, cycles from mem_rd asserted with a stable address until mem_rdata is valid (legal range 1..15).
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request strobe; accepted only when req_ready=1.
- req_ready  out  1  high only in IDLE.
- req_kind  in  2  00 fetch, 01 load, 10 store, 11 illegal.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  loads only: 1 sign-extends, 0 zero-extends.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- mem_addr  out  ADDR_W  word-aligned address ({req_addr[ADDR_W-1:2],2'b00}), held for the whole access.
- mem_rd  out  1  memory read enable.
- mem_wr  out  1  memory write enable, asserted for exactly one cycle per store.
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  memory read data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  32  fetched word, or extracted and extended load value; held until the next rsp_valid.
- ir_load  out  1  equals rsp_valid for fetch requests (IR write enable).
- exc_align  out  1  one-cycle pulse on a misaligned or illegal request.
- busy  out  1  inverse of req_ready.

Behaviour:
- Byte order is little-endian. Byte lane k sits at mem_rdata[8k+7:8k] and is selected by addr[1:0]. A halfword uses lane pair addr[1].
- States are IDLE, RD_WAIT, RESP, WRITE and ERR. All outputs are registered and decoded from state (Moore).
- Reset (async, while reset=0):
  - state=IDLE, counter=0.
  - All outputs 0 except req_ready=1. rsp_data=0, mem_addr=0, mem_wdata=0.
  - Reset during RD_WAIT or WRITE aborts the access immediately. No write may be issued after reset deasserts.
- Acceptance: in IDLE with req_valid=1. The block latches kind, size, signed, addr and wdata. req_valid outside IDLE is ignored; there is no queue.
- Error check at acceptance. Any of the following goes to ERR:
  - kind=11 or size=11.
  - Half access with addr[0]=1.
  - Word access or fetch with addr[1:0]!=0.
  - Fetch with size other than word.
- ERR lasts one cycle with exc_align=1 and no mem_rd/mem_wr, then returns to IDLE.
- Fetch, load and sub-word store go to RD_WAIT:
  - mem_rd=1 for exactly MEM_LAT cycles while the counter counts 0..MEM_LAT-1.
  - mem_rdata is captured on the clock edge that ends the cycle where counter=MEM_LAT-1.
- Fetch or load then goes to RESP for one cycle: rsp_valid=1, rsp_data = extracted value, ir_load=1 if fetch. Completion is cycle MEM_LAT+1 after acceptance (acceptance cycle = 0).
- Sub-word store then goes to WRITE:
  - mem_wdata = captured word with the addressed lane(s) replaced by req_wdata[7:0] or [15:0].
  - mem_wr=1 and rsp_valid=1 in the same cycle. Completion is cycle MEM_LAT+1.
- SW goes straight to WRITE: mem_wdata=req_wdata, mem_wr=1, rsp_valid=1 at cycle 1. No read is issued.
- Every state returns to IDLE on the following edge. A back-to-back request can be accepted in the first IDLE cycle after completion.
- mem_rd and mem_wr are never high together. mem_addr never changes while mem_rd or mem_wr is high.
- Load extension: byte gives {24{s&b[7]}},b; half gives {16{s&h[15]}},h. req_signed is ignored for fetch and store.

Decomposition:
- Shared package (cpu_pkg) holds:
  - req_kind codes: KIND_FETCH, KIND_LOAD, KIND_STORE.
  - req_size codes: SZ_BYTE, SZ_HALF, SZ_WORD.
  - State encoding localparams.
- Sub-module byte_lane_unit (combinational) contains the lane extraction/extension for loads and the lane merge for stores. It is reused by the load/store datapath later.
- The FSM and counter stay in mem_access_ctrl.

Test Plan:
- Fetch: MEM_LAT=3, addr 0x0000_0010, mem_rdata=0x8C22_0004 → mem_rd high cycles 1–3, rsp_valid and ir_load at cycle 4, rsp_data=0x8C22_0004.
- LB signed at addr 0x13 with word 0x80FF_1234 → rsp_data=0xFFFF_FF80. LBU at the same address → 0x0000_0080. LH signed at 0x12 → 0xFFFF_80FF.
- SB: addr 0x21, wdata 0xAB, memory word 0x1122_3344 → single mem_wr at cycle 4, mem_wdata=0x1122_AB44, mem_addr=0x20.
- SW at 0x24 with wdata 0xDEAD_BEEF → mem_wr and rsp_valid at cycle 1, no mem_rd. LW at 0x26 → exc_align pulse at cycle 1, no memory enable, req_ready=1 at cycle 2.
- Assert reset=0 at cycle 2 of an SH read phase → outputs cleared asynchronously, no mem_wr ever. After release, a fetch completes normally.
- req_valid held high through a load → second request accepted only in the first IDLE cycle after rsp_valid, and no request is lost or duplicated.
